// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Instruction sequencer for a small accumulator CPU. Fetches
//               from a 32-word program store, executes ordinary words in
//               one cycle, handles two-word JMP/JC, a HALT opcode,
//               run/stop control and single-stepping, and counts retired
//               instructions (saturating at 255).
// Ports       : clk      - system clock, rising edge
//               nReset   - asynchronous active-low reset
//               Run      - level run request (rising edge starts)
//               Step     - single-step request, honoured only in HALT
//               Ins[5:0] - instruction word at Addr
//               CY       - datapath carry, used by JC
//               Addr     - registered program address
//               ExecEn   - datapath enable qualifier
//               Halted   - sequencer is in HALT
//               StepDone - one-cycle pulse after a single step completes
//               RetCnt   - retired instruction count, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer (
    input  logic       clk,
    input  logic       nReset,
    input  logic       Run,
    input  logic       Step,
    input  logic [5:0] Ins,
    input  logic       CY,
    output logic [4:0] Addr,
    output logic       ExecEn,
    output logic       Halted,
    output logic       StepDone,
    output logic [7:0] RetCnt
);

    localparam logic [5:0] c_OP_HALT = 6'b111101;
    // JMP = 111110, JC = 111111: they share the top five bits and Ins[0]
    // tells them apart.
    localparam logic [4:0] c_OP_JUMP_HI = 5'b11111;

    localparam logic [1:0] c_ST_HALT = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_JTGT = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [4:0] r_addr;
    logic [4:0] w_addr_nxt;
    logic       r_run_q;
    logic       r_stepping;
    logic       w_stepping_nxt;
    logic       r_jump_is_jc;
    logic       w_jump_is_jc_nxt;
    logic [7:0] r_ret_cnt;
    logic       r_step_done;
    logic       w_step_done_nxt;
    logic       w_retire;
    logic       w_exec_en;
    logic       w_boundary;
    logic       w_force_halt;
    logic       w_is_halt;
    logic       w_is_jump;
    logic       w_take_jump;

    assign w_is_halt   = (Ins == c_OP_HALT);
    assign w_is_jump   = (Ins[5:1] == c_OP_JUMP_HI);
    assign w_take_jump = !r_jump_is_jc || CY;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state      <= c_ST_HALT;
            r_addr       <= 5'd0;
            r_run_q      <= 1'b0;
            r_stepping   <= 1'b0;
            r_jump_is_jc <= 1'b0;
            r_ret_cnt    <= 8'd0;
            r_step_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_run_q      <= Run;
            r_stepping   <= w_stepping_nxt;
            r_jump_is_jc <= w_jump_is_jc_nxt;
            r_step_done  <= w_step_done_nxt;
            if (w_retire && (r_ret_cnt != 8'hFF)) begin
                r_ret_cnt <= r_ret_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_stepping_nxt   = r_stepping;
        w_jump_is_jc_nxt = r_jump_is_jc;
        w_step_done_nxt  = 1'b0;
        w_retire         = 1'b0;
        w_exec_en        = 1'b0;
        w_boundary       = 1'b0;
        w_force_halt     = 1'b0;

        case (r_state)
            c_ST_HALT: begin
                // A fresh Run edge beats a simultaneous Step.
                if (Run && !r_run_q) begin
                    w_state_nxt    = c_ST_EXEC;
                    w_stepping_nxt = 1'b0;
                end else if (Step) begin
                    w_state_nxt    = c_ST_EXEC;
                    w_stepping_nxt = 1'b1;
                end
            end
            c_ST_EXEC: begin
                if (w_is_halt) begin
                    // Address stays on the HALT word so a restart re-executes it.
                    w_retire     = 1'b1;
                    w_boundary   = 1'b1;
                    w_force_halt = 1'b1;
                end else if (w_is_jump) begin
                    w_addr_nxt       = r_addr + 5'd1;
                    w_jump_is_jc_nxt = Ins[0];
                    w_state_nxt      = c_ST_JTGT;
                end else begin
                    w_exec_en  = 1'b1;
                    w_addr_nxt = r_addr + 5'd1;
                    w_retire   = 1'b1;
                    w_boundary = 1'b1;
                end
            end
            c_ST_JTGT: begin
                // Ins here is the target word; its bit 5 is not part of the target.
                w_retire   = 1'b1;
                w_boundary = 1'b1;
                w_addr_nxt = w_take_jump ? Ins[4:0] : (r_addr + 5'd1);
            end
            default: begin
                w_state_nxt = c_ST_HALT;
            end
        endcase

        // Instruction boundary: decide whether to keep running.
        if (w_boundary) begin
            if (r_stepping) begin
                w_state_nxt     = c_ST_HALT;
                w_step_done_nxt = 1'b1;
                w_stepping_nxt  = 1'b0;
            end else if (!Run || w_force_halt) begin
                w_state_nxt = c_ST_HALT;
            end else begin
                w_state_nxt = c_ST_EXEC;
            end
        end
    end

    assign Addr     = r_addr;
    assign ExecEn   = w_exec_en;
    assign Halted   = (r_state == c_ST_HALT);
    assign StepDone = r_step_done;
    assign RetCnt   = r_ret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Directed self-checking bench for cpu_sequencer. A small
//               program memory model feeds Ins from Addr; a vector table
//               covers a jump program and hand sequences cover halt,
//               single-step, reset and saturation corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam logic [5:0] c_HALT = 6'b111101;
    localparam logic [5:0] c_JMP  = 6'b111110;
    localparam logic [5:0] c_JC   = 6'b111111;
    localparam int         c_NVEC = 18;

    logic       clk;
    logic       nReset;
    logic       Run;
    logic       Step;
    logic [5:0] Ins;
    logic       CY;
    logic [4:0] Addr;
    logic       ExecEn;
    logic       Halted;
    logic       StepDone;
    logic [7:0] RetCnt;

    logic [5:0] mem [32];

    int checks;
    int failures;

    typedef struct {
        logic       run;
        logic       step;
        logic       cy;
        logic [4:0] addr;
        logic       exec_en;
        logic       halted;
        logic       step_done;
    } vec_t;

    vec_t vecs [c_NVEC];

    cpu_sequencer dut (
        .clk      (clk),
        .nReset   (nReset),
        .Run      (Run),
        .Step     (Step),
        .Ins      (Ins),
        .CY       (CY),
        .Addr     (Addr),
        .ExecEn   (ExecEn),
        .Halted   (Halted),
        .StepDone (StepDone),
        .RetCnt   (RetCnt)
    );

    assign Ins = mem[Addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 6'd0;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        Run    = 1'b0;
        Step   = 1'b0;
        CY     = 1'b0;
        tick();
        tick();
        nReset = 1'b1;
    endtask

    task automatic set_vec(input int i, input logic run, input logic step, input logic cy,
                           input logic [4:0] addr, input logic ee, input logic h, input logic sd);
        vecs[i].run       = run;
        vecs[i].step      = step;
        vecs[i].cy        = cy;
        vecs[i].addr      = addr;
        vecs[i].exec_en   = ee;
        vecs[i].halted    = h;
        vecs[i].step_done = sd;
    endtask

    initial begin
        int sd_count;
        checks   = 0;
        failures = 0;
        nReset   = 1'b0;
        Run      = 1'b0;
        Step     = 1'b0;
        CY       = 1'b0;
        clear_mem();

        // Jump program vectors: run, step, cy | expected addr, ExecEn, Halted, StepDone
        set_vec( 0, 1, 0, 0,  0, 0, 1, 0);
        set_vec( 1, 1, 0, 0,  0, 1, 0, 0);
        set_vec( 2, 1, 1, 0,  1, 1, 0, 0);  // Step in EXEC is ignored
        set_vec( 3, 1, 0, 0,  2, 1, 0, 0);
        set_vec( 4, 1, 0, 0,  3, 1, 0, 0);
        set_vec( 5, 1, 0, 0,  4, 0, 0, 0);  // JMP
        set_vec( 6, 1, 0, 0,  5, 0, 0, 0);  // target word 18
        set_vec( 7, 1, 0, 0, 18, 0, 0, 0);  // JC
        set_vec( 8, 1, 0, 0, 19, 0, 0, 0);  // CY=0, falls through
        set_vec( 9, 1, 0, 0, 20, 1, 0, 0);
        set_vec(10, 1, 0, 0, 21, 1, 0, 0);
        set_vec(11, 1, 0, 0, 22, 0, 0, 0);  // JMP
        set_vec(12, 1, 0, 0, 23, 0, 0, 0);  // target 18 with bit 5 set
        set_vec(13, 1, 0, 0, 18, 0, 0, 0);  // JC
        set_vec(14, 1, 0, 1, 19, 0, 0, 0);  // CY=1, taken to 7
        set_vec(15, 1, 0, 0,  7, 1, 0, 0);
        set_vec(16, 0, 0, 0,  8, 1, 0, 0);  // Run drops, stops after this one
        set_vec(17, 0, 0, 0,  9, 0, 1, 0);

        // ---------------- reset state ----------------
        tick();
        check("rst_addr", Addr, 0);
        check("rst_halted", Halted, 1);
        check("rst_execen", ExecEn, 0);
        check("rst_stepdone", StepDone, 0);
        check("rst_retcnt", RetCnt, 0);

        // ---------------- linear program ----------------
        do_reset();
        Run = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("lin_addr%0d", i), Addr, i);
            check($sformatf("lin_ee%0d", i), ExecEn, 1);
            tick();
        end
        check("lin_wrap_addr", Addr, 0);
        check("lin_retcnt", RetCnt, 32);

        // ---------------- jump program, table driven ----------------
        clear_mem();
        mem[4]  = c_JMP;
        mem[5]  = 6'b010010;
        mem[18] = c_JC;
        mem[19] = 6'b000111;
        mem[22] = c_JMP;
        mem[23] = 6'b110010;
        do_reset();
        for (int i = 0; i < c_NVEC; i++) begin
            Run  = vecs[i].run;
            Step = vecs[i].step;
            CY   = vecs[i].cy;
            check($sformatf("vec%0d_addr", i), Addr, vecs[i].addr);
            check($sformatf("vec%0d_ee", i), ExecEn, vecs[i].exec_en);
            check($sformatf("vec%0d_halted", i), Halted, vecs[i].halted);
            check($sformatf("vec%0d_sd", i), StepDone, vecs[i].step_done);
            tick();
        end
        check("jmp_retcnt", RetCnt, 12);

        // ---------------- HALT instruction ----------------
        clear_mem();
        mem[3] = c_HALT;
        do_reset();
        Run = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("hlt_halted", Halted, 1);
        check("hlt_addr", Addr, 3);
        check("hlt_retcnt", RetCnt, 4);
        tick();
        tick();
        check("hlt_stable_halted", Halted, 1);
        check("hlt_stable_addr", Addr, 3);
        Run = 1'b0;
        tick();
        Run = 1'b1;
        tick();
        check("hlt_restart_exec", Halted, 0);
        tick();
        check("hlt_rehalt", Halted, 1);
        check("hlt_rehalt_addr", Addr, 3);
        check("hlt_rehalt_retcnt", RetCnt, 5);
        check("hlt_no_sd", StepDone, 0);

        // ---------------- single step ----------------
        clear_mem();
        mem[1] = c_JMP;
        mem[2] = 6'b010110;
        do_reset();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        check("st1_running", Halted, 0);
        check("st1_ee", ExecEn, 1);
        tick();
        check("st1_addr", Addr, 1);
        check("st1_halted", Halted, 1);
        check("st1_sd", StepDone, 1);
        tick();
        check("st1_sd_clear", StepDone, 0);
        check("st1_hold_addr", Addr, 1);
        Step = 1'b1;
        tick();
        Step = 1'b0;
        sd_count = 0;
        for (int i = 0; i < 4; i++) begin
            if (StepDone === 1'b1) sd_count++;
            tick();
        end
        check("st2_addr", Addr, 22);
        check("st2_halted", Halted, 1);
        check("st2_sd_count", sd_count, 1);

        // ---------------- Run and Step together ----------------
        clear_mem();
        do_reset();
        Run  = 1'b1;
        Step = 1'b1;
        sd_count = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (StepDone === 1'b1) sd_count++;
        end
        Step = 1'b0;
        check("rs_running", Halted, 0);
        check("rs_addr", Addr, 3);
        check("rs_no_sd", sd_count, 0);

        // ---------------- Run dropped in JTGT ----------------
        clear_mem();
        mem[2] = c_JMP;
        mem[3] = 6'b011001;
        do_reset();
        Run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rj_in_jtgt_addr", Addr, 3);
        Run = 1'b0;
        tick();
        check("rj_halted", Halted, 1);
        check("rj_addr", Addr, 25);

        // ---------------- reset in JTGT ----------------
        do_reset();
        Run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rr_pre_addr", Addr, 3);
        check("rr_pre_halted", Halted, 0);
        nReset = 1'b0;
        #1;
        check("rr_addr", Addr, 0);
        check("rr_halted", Halted, 1);
        check("rr_retcnt", RetCnt, 0);
        tick();

        // ---------------- Run held through reset, then saturation ----------------
        clear_mem();
        Run = 1'b1;
        tick();
        nReset = 1'b1;
        tick();
        check("rh_start", Halted, 0);
        check("rh_ee", ExecEn, 1);
        for (int i = 0; i < 254; i++) tick();
        check("sat_254", RetCnt, 254);
        for (int i = 0; i < 46; i++) tick();
        check("sat_255", RetCnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
